seq_gen_tx: RTL and testbench



---
 rtl/seq_gen_pkg.sv | 13 +
 rtl/piso_shreg.sv | 27 ++
 rtl/seq_gen_tx.sv | 112 +++++++++++
 tb/tb_seq_gen_tx.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// rtl/seq_gen_pkg.sv - shared state encoding and defaults for the serial pattern transmitter
package seq_gen_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/piso_shreg.sv
// rtl/piso_shreg.sv - parallel-load, serial-out shift register, MSB first, zero fill
module piso_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign sout = q[WIDTH-1];

endmodule

// File: rtl/seq_gen_tx.sv
// rtl/seq_gen_tx.sv - serial pattern transmitter with repeat count feeding the sequence detector
module seq_gen_tx
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             ready,
  output logic             x,
  output logic             x_valid,
  output logic             done,
  output logic [1:0]       ps,
  output logic [1:0]       ns
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [BW-1:0]    bit_cnt;
  logic [CNT_W-1:0] reps;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] load_data;
  logic             load, shift, accept, reload, cnt_dec;

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    shift     = 1'b0;
    load_data = '0;
    accept    = 1'b0;
    reload    = 1'b0;
    cnt_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          load      = 1'b1;
          load_data = pattern;
          accept    = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_cnt != '0) begin
          shift   = 1'b1;
          cnt_dec = 1'b1;
        end else if (reps != CNT_W'(1)) begin
          // reload straight from the captured copy so repeats run with no gap bit
          load      = 1'b1;
          load_data = pat_q;
          reload    = 1'b1;
        end else begin
          // the final shift empties the register, which drives x low in DONE
          state_d = DONE;
          shift   = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        load    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_valid <= 1'b0;
      done    <= 1'b0;
      ready   <= 1'b1;
      bit_cnt <= '0;
      reps    <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      x_valid <= (state_d == SHIFT);
      done    <= (state_d == DONE);
      ready   <= (state_d == IDLE);
      if (accept) begin
        pat_q   <= pattern;
        bit_cnt <= LAST_BIT;
        reps    <= (repeat_n == '0) ? CNT_W'(1) : repeat_n;
      end else if (reload) begin
        bit_cnt <= LAST_BIT;
        reps    <= reps - CNT_W'(1);
      end else if (cnt_dec) begin
        bit_cnt <= bit_cnt - BW'(1);
      end
    end
  end

  piso_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .shift(shift),
    .din  (load_data),
    .sout (x)
  );

  assign ps = state_q;
  assign ns = state_d;

endmodule

// File: tb/tb_seq_gen_tx.sv
// tb/tb_seq_gen_tx.sv - directed self-checking bench for seq_gen_tx
module tb_seq_gen_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] repeat_n;
  logic       ready, x, x_valid, done;
  logic [1:0] ps, ns;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_gen_tx #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .repeat_n(repeat_n),
    .ready   (ready),
    .x       (x),
    .x_valid (x_valid),
    .done    (done),
    .ps      (ps),
    .ns      (ns)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, ready, 1'b1);
    chk({tag, "_x"}, x, 1'b0);
    chk({tag, "_xv"}, x_valid, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk2({tag, "_ps"}, ps, 2'd0);
  endtask

  // poke_at >= 0: at that bit index, pulse start and scramble the inputs
  task automatic run_xfer(input string tag, input logic [7:0] pat, input logic [3:0] rn,
                          input int nrep, input int poke_at);
    pattern  = pat;
    repeat_n = rn;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < nrep * 8; k++) begin
      chk({tag, "_x"}, x, pat[7 - (k % 8)]);
      chk({tag, "_xv"}, x_valid, 1'b1);
      chk({tag, "_done_lo"}, done, 1'b0);
      chk({tag, "_rdy_lo"}, ready, 1'b0);
      chk2({tag, "_ps_shift"}, ps, 2'd1);
      if (k == poke_at) begin
        start    = 1'b1;
        pattern  = ~pat;
        repeat_n = 4'd5;
      end
      tick();
      start = 1'b0;
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_x_done"}, x, 1'b0);
    chk({tag, "_xv_done"}, x_valid, 1'b0);
    chk({tag, "_rdy_done"}, ready, 1'b0);
    chk2({tag, "_ps_done"}, ps, 2'd2);
    tick();
    chk_idle({tag, "_ret"});
    tick();
    chk_idle({tag, "_stay"});
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    pattern  = 8'h00;
    repeat_n = 4'd0;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle("reset");
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("idle");
      chk2("idle_ns", ns, 2'd0);
    end

    run_xfer("b4x1", 8'hB4, 4'd1, 1, -1);
    run_xfer("0fx3", 8'h0F, 4'd3, 3, -1);
    run_xfer("81x0", 8'h81, 4'd0, 1, -1);
    run_xfer("poke", 8'h5C, 4'd1, 1, 3);

    pattern  = 8'hC3;
    repeat_n = 4'd1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("abort_x", x, pattern[7 - k]);
      chk("abort_xv", x_valid, 1'b1);
      tick();
    end
    chk("abort_x5", x, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("abort");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("post_abort");
    end

    run_xfer("aa", 8'hAA, 4'd1, 1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
